bus_protocol_master: RTL
========================

// Module: bus_protocol_master
// PURPOSE
//  Transmit side of the 8-bit dValid/dAck byte bus; sits directly upstream of the target.
//  Accepts bytes on a valid/ready input and buffers them in a small FIFO.
//  Drives each byte as one dValid burst that satisfies the bus rules: dValid high 3..5 cycles,
//  data known and stable, and drop one cycle after the dAck rise.
//  Retries when the target does not acknowledge, then discards the byte with an error.
// PARAMETERS
//  DEPTH      4   FIFO entries, power of 2, >=2
//  MAX_RETRY  2   re-sends after a failed attempt before the byte is dropped (0..7)
// PORTS
//  clk         in   1  single clock, all logic on posedge
//  reset       in   1  synchronous, active-high
//  in_valid    in   1  upstream byte valid
//  in_data     in   8  upstream byte
//  in_ready    out  1  = !fifo_full; push on in_valid&&in_ready
//  dValid      out  1  bus valid, registered
//  data        out  8  bus data, registered
//  dAck        in   1  target acknowledge
//  busy        out  1  attempt in progress or FIFO non-empty
//  err_noack   out  1  1-cycle pulse per failed attempt (no valid dAck rise)
//  err_drop    out  1  1-cycle pulse when a byte is discarded after MAX_RETRY
//  fifo_count  out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset: dValid=0, data=8'h00, err_*=0, FIFO emptied, retry count 0, state IDLE; in_ready=1 the cycle after.
//  Reset mid-burst: dValid low in the cycle after reset is sampled; byte lost with no error pulse.
//  Cycle T0 = first cycle with dValid=1. ackrise = dAck && !dAck_q, where dAck_q is dAck registered.
//  IDLE: FIFO non-empty and not reset -> dValid=1, data=head in the next cycle (T0). State DRIVE, cyc=0.
//  DRIVE: cyc increments every cycle. data=head and is held constant for the whole burst.
//   - ackrise sampled in T2, T3 or T4 -> dValid=0 next cycle. FIFO pop, retry:=0, state IDLE. Success.
//   - dAck high in T0 or T1 (early/stuck ack) -> err_noack pulse, and the attempt is marked failed.
//     dValid stays high through T2 and falls in T3.
//   - No ackrise by T4 -> dValid=0 in T5, err_noack pulse in T5.
//   - Failed attempt: if retry<MAX_RETRY, retry++ and the same byte is re-sent from IDLE.
//     Otherwise: pop, err_drop pulse in the same cycle as err_noack, retry:=0.
//  Min gap: dValid low >=1 cycle between bursts; a new T0 never starts in the cycle dValid falls.
//  When not driving, data holds the last byte driven (never X).
//  FIFO: push and pop in the same cycle allowed, count unchanged. No push when full (in_ready=0).
//   Pop only on burst end. Pointers wrap modulo DEPTH.
//  Guaranteed: dValid high 3..5 cycles per burst; only reset can end a burst outside that window.
//  in_data is not sampled when in_ready=0.
// STRUCTURE
//  bus_protocol_pkg:
//   - state_e {IDLE,DRIVE}
//   - VALID_MIN_CYC=3, VALID_MAX_CYC=5, ACK_FIRST_CYC=2, ACK_LAST_CYC=4
//  Sub-module bus_byte_fifo (#DEPTH): sync FIFO with push/pop/head/full/empty/count.
//  The FSM, burst cycle counter, retry counter and dAck_q live in the top.
// TESTING
//  1 Push 8'hA5; target raises dAck in T2 -> dValid high T0..T2, low T3; data=A5 throughout.
//    FIFO empty, no errors.
//  2 Push 3 bytes back-to-back; target acks in T4 each time.
//    -> 3 bursts of 5 cycles, 1-cycle gaps, order preserved, busy drops after the last burst.
//  3 DEPTH=4, hold dAck low, push 5 bytes -> in_ready=0 after the 4th push.
//    Each byte: 3 attempts (MAX_RETRY=2), err_noack x3, then err_drop; dValid falls in T5 each attempt.
//  4 dAck high in T1 -> err_noack in T3 and dValid falls in T3.
//    Byte re-sent; dAck rising in T3 of the retry succeeds.
//  5 Reset asserted in T1 of a burst -> dValid=0 and fifo_count=0 next cycle.
//    No err pulses; a later push transfers normally.
//  6 Concurrent assertions on every run:
//    - $rose(dValid) |=> dValid[*2] ##[1:3] $fell(dValid)
//    - data known and $stable while dValid
//    - err_drop implies err_noack

Source files
------------

// File: rtl/bus_protocol_pkg.sv
// Shared types and burst timing constants for the dValid/dAck byte-bus master.
package bus_protocol_pkg;

  typedef enum logic {IDLE, DRIVE} state_e;

  // Burst cycle indices are counted from T0 = first cycle with dValid high.
  localparam logic [2:0] VALID_MIN_CYC = 3'd3;
  localparam logic [2:0] VALID_MAX_CYC = 3'd5;
  localparam logic [2:0] ACK_FIRST_CYC = 3'd2;
  localparam logic [2:0] ACK_LAST_CYC  = 3'd4;

endpackage

// File: rtl/bus_byte_fifo.sv
// Synchronous byte FIFO with registered occupancy count.
// Ignores a push while full and a pop while empty.
module bus_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd];
  assign count  = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_protocol_master.sv
// Byte-bus transmitter: buffers input bytes and drives each as one 3..5 cycle dValid burst,
// retrying unacknowledged bytes up to MAX_RETRY times before dropping them with err_drop.
module bus_protocol_master
  import bus_protocol_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     dValid,
  output logic [7:0]               data,
  input  logic                     dAck,
  output logic                     busy,
  output logic                     err_noack,
  output logic                     err_drop,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  state_e     r_state;
  logic [2:0] r_cyc;
  logic [2:0] r_retry;
  logic       r_fail;
  logic       r_dack_q;

  logic       w_push;
  logic       w_pop;
  logic [7:0] w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_driving;
  logic       w_ackrise;
  logic       w_ok;
  logic       w_early;
  logic       w_fail_end;
  logic       w_drop;

  bus_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (in_data),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  assign in_ready  = !w_full;
  assign w_push    = in_valid && in_ready;
  assign w_driving = (r_state == DRIVE);
  assign busy      = w_driving || !w_empty;
  assign w_ackrise = dAck && !r_dack_q;

  // An ack level seen before T2 poisons the attempt; it then ends at the minimum length.
  assign w_early    = w_driving && dAck && (r_cyc < ACK_FIRST_CYC);
  assign w_ok       = w_driving && !r_fail && w_ackrise &&
                      (r_cyc >= ACK_FIRST_CYC) && (r_cyc <= ACK_LAST_CYC);
  assign w_fail_end = w_driving && !w_ok &&
                      ((r_fail && (r_cyc == VALID_MIN_CYC - 3'd1)) ||
                       (r_cyc == VALID_MAX_CYC - 3'd1));
  assign w_drop     = w_fail_end && (r_retry >= MAX_R);
  assign w_pop      = w_ok || w_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cyc     <= '0;
      r_retry   <= '0;
      r_fail    <= 1'b0;
      r_dack_q  <= 1'b0;
      dValid    <= 1'b0;
      data      <= 8'h00;
      err_noack <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      r_dack_q  <= dAck;
      err_noack <= 1'b0;
      err_drop  <= 1'b0;
      case (r_state)
        IDLE: begin
          // IDLE always lasts at least one cycle, which gives the mandatory gap.
          if (!w_empty) begin
            dValid  <= 1'b1;
            data    <= w_head;
            r_cyc   <= '0;
            r_fail  <= 1'b0;
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          r_cyc <= r_cyc + 3'd1;
          if (w_early) r_fail <= 1'b1;
          if (w_ok) begin
            dValid  <= 1'b0;
            r_retry <= '0;
            r_state <= IDLE;
          end else if (w_fail_end) begin
            dValid    <= 1'b0;
            err_noack <= 1'b1;
            r_state   <= IDLE;
            if (w_drop) begin
              err_drop <= 1'b1;
              r_retry  <= '0;
            end else begin
              r_retry <= r_retry + 3'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
